pipeline_sequencer: RTL and testbench

- Central control for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB). Sequences execution in continuous-run and single-step modes.
- Detects load-use hazards between ID/EX and IF/ID and inserts stalls. Flushes IF/ID on taken branches.
- Drains the pipeline after a HALT instruction is decoded in ID.
- Drives the enables of the PC, IF/ID and the remaining pipeline latches, plus the ID/EX control-bubble select.

---
 rtl/pipeline_sequencer.sv | 142 ++++++++++++++
 tb/tb_pipeline_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer for the 5-stage MIPS core: run/step control, load-use stalls, branch flushes, HALT drain.
// Optional macro STALL_COUNTER_EN adds the saturating o_stall_count output.
module pipeline_sequencer #(
  parameter int NB_address_registros = 5,
  parameter int NB_CYCLES            = 32,
  parameter int DRAIN_CYCLES         = 4,
  parameter int NB_STATE             = 3
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_start,
  input  logic                            i_step_mode,
  input  logic                            i_step,
  input  logic                            i_halt_id,
  input  logic                            i_branch_taken,
  input  logic                            i_id_ex_MemRead,
  input  logic [NB_address_registros-1:0] i_id_ex_rt,
  input  logic [NB_address_registros-1:0] i_if_id_rs,
  input  logic [NB_address_registros-1:0] i_if_id_rt,
  output logic                            o_pc_enable,
  output logic                            o_if_id_enable,
  output logic                            o_if_id_flush,
  output logic                            o_id_ex_bubble,
  output logic                            o_pipe_enable,
  output logic [NB_STATE-1:0]             o_state,
  output logic [NB_CYCLES-1:0]            o_cycle_count,
  output logic                            o_done
`ifdef STALL_COUNTER_EN
  ,
  output logic [NB_CYCLES-1:0]            o_stall_count
`endif
);

  localparam int NB_DRAIN = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [NB_STATE-1:0] {
    IDLE      = NB_STATE'(0),
    RUN       = NB_STATE'(1),
    STEP_WAIT = NB_STATE'(2),
    STEP_EXEC = NB_STATE'(3),
    DRAIN     = NB_STATE'(4),
    DONE      = NB_STATE'(5)
  } state_t;

  state_t                state, state_next;
  logic [NB_DRAIN-1:0]   drain_cnt, drain_next;
  logic [NB_CYCLES-1:0]  cycle_cnt;
  logic                  act, exec, load_use, stall, flush, halt_acc;

  // Hazards only matter while an instruction is actually advancing; DRAIN ignores them.
  assign act      = (state == RUN) || (state == STEP_EXEC) || (state == DRAIN);
  assign exec     = (state == RUN) || (state == STEP_EXEC);
  assign load_use = i_id_ex_MemRead && (i_id_ex_rt != '0) &&
                    ((i_id_ex_rt == i_if_id_rs) || (i_id_ex_rt == i_if_id_rt));
  assign stall    = exec && load_use;
  assign flush    = exec && i_branch_taken;
  assign halt_acc = exec && i_halt_id && !stall && !flush;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
      cycle_cnt <= '0;
    end else begin
      state     <= state_next;
      drain_cnt <= drain_next;
      if (act) cycle_cnt <= cycle_cnt + NB_CYCLES'(1);
    end
  end

  always_comb begin
    state_next = state;
    drain_next = drain_cnt;
    case (state)
      IDLE:      if (i_start) state_next = i_step_mode ? STEP_WAIT : RUN;
      RUN: begin
        if (halt_acc) begin
          state_next = DRAIN;
          drain_next = NB_DRAIN'(DRAIN_CYCLES - 1);
        end
      end
      STEP_WAIT: if (i_step) state_next = STEP_EXEC;
      STEP_EXEC: begin
        state_next = STEP_WAIT;
        if (halt_acc) begin
          state_next = DRAIN;
          drain_next = NB_DRAIN'(DRAIN_CYCLES - 1);
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) state_next = DONE;
        else                 drain_next = drain_cnt - NB_DRAIN'(1);
      end
      DONE:      if (i_start) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Output priority in RUN/STEP_EXEC: flush, then stall, then halt accept, then normal flow.
  always_comb begin
    o_pc_enable    = 1'b0;
    o_if_id_enable = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b0;
    if (exec) begin
      if (flush) begin
        o_pc_enable    = 1'b1;
        o_if_id_enable = 1'b1;
        o_if_id_flush  = 1'b1;
        o_id_ex_bubble = 1'b1;
      end else if (stall) begin
        o_id_ex_bubble = 1'b1;
      end else if (halt_acc) begin
        o_if_id_enable = 1'b1;
        o_if_id_flush  = 1'b1;
      end else begin
        o_pc_enable    = 1'b1;
        o_if_id_enable = 1'b1;
      end
    end else if (state == DRAIN) begin
      o_if_id_enable = 1'b1;
      o_if_id_flush  = 1'b1;
    end
  end

  assign o_pipe_enable = act;
  assign o_state       = state;
  assign o_cycle_count = cycle_cnt;
  assign o_done        = (state == DONE);

`ifdef STALL_COUNTER_EN
  logic [NB_CYCLES-1:0] stall_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst)                                   stall_cnt <= '0;
    else if (act && stall && !flush && stall_cnt != '1) stall_cnt <= stall_cnt + NB_CYCLES'(1);
  end

  assign o_stall_count = stall_cnt;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed self-checking bench for pipeline_sequencer: reset/start, load-use, flush priority,
// halt drain, single-step and reset during drain.
module tb_pipeline_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, start, step_mode, step, halt_id, branch_taken, memread;
  logic [4:0] ex_rt, id_rs, id_rt;
  logic       pc_en, if_id_en, if_id_flush, bubble, pipe_en, done;
  logic [2:0] state;
  logic [31:0] cycle_count;
`ifdef STALL_COUNTER_EN
  logic [31:0] stall_count;
`endif

  int checks   = 0;
  int failures = 0;

  // {pc, if_id, flush, bubble, pipe}
  logic [4:0] ctl;
  assign ctl = {pc_en, if_id_en, if_id_flush, bubble, pipe_en};

  always #5 clk = ~clk;

  pipeline_sequencer dut (
    .i_clk           (clk),
    .i_rst           (rst_n),
    .i_start         (start),
    .i_step_mode     (step_mode),
    .i_step          (step),
    .i_halt_id       (halt_id),
    .i_branch_taken  (branch_taken),
    .i_id_ex_MemRead (memread),
    .i_id_ex_rt      (ex_rt),
    .i_if_id_rs      (id_rs),
    .i_if_id_rt      (id_rt),
    .o_pc_enable     (pc_en),
    .o_if_id_enable  (if_id_en),
    .o_if_id_flush   (if_id_flush),
    .o_id_ex_bubble  (bubble),
    .o_pipe_enable   (pipe_en),
    .o_state         (state),
    .o_cycle_count   (cycle_count),
    .o_done          (done)
`ifdef STALL_COUNTER_EN
    ,
    .o_stall_count   (stall_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; step_mode = 0; step = 0; halt_id = 0; branch_taken = 0;
    memread = 0; ex_rt = 0; id_rs = 0; id_rt = 0;
  endtask

  task automatic reset_start(input logic mode);
    clear_inputs();
    rst_n = 0;
    tick(); tick();
    rst_n = 1; start = 1; step_mode = mode;
    tick();
    start = 0; step_mode = 0;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    tick(); tick();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state actual=%0d expected=0", state); end
    checks++; if (ctl !== 5'b00000) begin failures++; $display("FAIL reset_ctl actual=%b expected=00000", ctl); end
    checks++; if (cycle_count !== 32'd0) begin failures++; $display("FAIL reset_cycles actual=%0d expected=0", cycle_count); end
    rst_n = 1; start = 1; step_mode = 0;
    #1;
    checks++; if (ctl !== 5'b00000) begin failures++; $display("FAIL idle_ctl actual=%b expected=00000", ctl); end
    tick();
    start = 0;
    #1;
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL start_state actual=%0d expected=1", state); end
    checks++; if (ctl !== 5'b11001) begin failures++; $display("FAIL run_ctl actual=%b expected=11001", ctl); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (cycle_count !== 32'd5) begin failures++; $display("FAIL run_cycles actual=%0d expected=5", cycle_count); end
  endtask

  task automatic test_load_use();
    reset_start(1'b0);
    memread = 1; ex_rt = 5'd2; id_rs = 5'd2; id_rt = 5'd0;
    #1;
    checks++; if (ctl !== 5'b00011) begin failures++; $display("FAIL stall_rs_ctl actual=%b expected=00011", ctl); end
    tick();
    memread = 0;
    #1;
    checks++; if (ctl !== 5'b11001) begin failures++; $display("FAIL post_stall_ctl actual=%b expected=11001", ctl); end
    checks++; if (cycle_count !== 32'd1) begin failures++; $display("FAIL stall_cycles actual=%0d expected=1", cycle_count); end
    memread = 1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    #1;
    checks++; if (ctl !== 5'b11001) begin failures++; $display("FAIL r0_no_stall actual=%b expected=11001", ctl); end
    ex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd7;
    #1;
    checks++; if (ctl !== 5'b00011) begin failures++; $display("FAIL stall_rt_ctl actual=%b expected=00011", ctl); end
    ex_rt = 5'd7; id_rs = 5'd3; id_rt = 5'd4;
    #1;
    checks++; if (ctl !== 5'b11001) begin failures++; $display("FAIL no_match_ctl actual=%b expected=11001", ctl); end
    id_rt = 5'd7;
    tick();
    clear_inputs();
    #1;
`ifdef STALL_COUNTER_EN
    checks++; if (stall_count !== 32'd2) begin failures++; $display("FAIL stall_count actual=%0d expected=2", stall_count); end
`endif
  endtask

  task automatic test_flush_priority();
    reset_start(1'b0);
    memread = 1; ex_rt = 5'd2; id_rs = 5'd2; branch_taken = 1; halt_id = 1;
    #1;
    checks++; if (ctl !== 5'b11111) begin failures++; $display("FAIL flush_ctl actual=%b expected=11111", ctl); end
    tick();
    clear_inputs();
    #1;
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL flush_state actual=%0d expected=1", state); end
`ifdef STALL_COUNTER_EN
    checks++; if (stall_count !== 32'd0) begin failures++; $display("FAIL flush_stall_count actual=%0d expected=0", stall_count); end
`endif
  endtask

  task automatic test_halt_drain();
    int n;
    reset_start(1'b0);
    halt_id = 1;
    #1;
    checks++; if (ctl !== 5'b01101) begin failures++; $display("FAIL halt_acc_ctl actual=%b expected=01101", ctl); end
    tick();
    halt_id = 0; branch_taken = 1; memread = 1; ex_rt = 5'd1; id_rs = 5'd1;
    #1;
    checks++; if (state !== 3'd4) begin failures++; $display("FAIL drain_state actual=%0d expected=4", state); end
    checks++; if (ctl !== 5'b01101) begin failures++; $display("FAIL drain_ctl actual=%b expected=01101", ctl); end
    clear_inputs();
    n = 1;
    while (n < 10) begin
      tick();
      if (state == 3'd4) n++;
      else break;
    end
    checks++; if (n !== 4) begin failures++; $display("FAIL drain_len actual=%0d expected=4", n); end
    checks++; if (state !== 3'd5 || done !== 1'b1) begin failures++; $display("FAIL done_state actual=%0d/%0b expected=5/1", state, done); end
    checks++; if (cycle_count !== 32'd5) begin failures++; $display("FAIL done_cycles actual=%0d expected=5", cycle_count); end
    tick(); tick(); tick();
    checks++; if (cycle_count !== 32'd5 || ctl !== 5'b00000) begin failures++; $display("FAIL done_frozen actual=%0d/%b expected=5/00000", cycle_count, ctl); end
    start = 1;
    tick();
    start = 0;
    #1;
    checks++; if (state !== 3'd0 || done !== 1'b0) begin failures++; $display("FAIL done_restart actual=%0d/%0b expected=0/0", state, done); end
  endtask

  task automatic test_step_mode();
    int highs;
    reset_start(1'b1);
    for (int i = 0; i < 10; i++) tick();
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL step_wait_state actual=%0d expected=2", state); end
    checks++; if (cycle_count !== 32'd0) begin failures++; $display("FAIL step_idle_cycles actual=%0d expected=0", cycle_count); end
    highs = 0;
    for (int c = 0; c < 12; c++) begin
      step = (c % 4 == 0);
      #1;
      if (pipe_en) highs++;
      tick();
    end
    step = 0;
    checks++; if (highs !== 3) begin failures++; $display("FAIL step_pipe_highs actual=%0d expected=3", highs); end
    checks++; if (cycle_count !== 32'd3) begin failures++; $display("FAIL step_cycles actual=%0d expected=3", cycle_count); end
    step = 1;
    tick();
    step = 0; memread = 1; ex_rt = 5'd9; id_rs = 5'd9;
    #1;
    checks++; if (state !== 3'd3 || ctl !== 5'b00011) begin failures++; $display("FAIL step_stall actual=%0d/%b expected=3/00011", state, ctl); end
    tick();
    clear_inputs();
    #1;
    checks++; if (state !== 3'd2 || cycle_count !== 32'd4) begin failures++; $display("FAIL step_consumed actual=%0d/%0d expected=2/4", state, cycle_count); end
  endtask

  task automatic test_reset_mid_drain();
    reset_start(1'b0);
    halt_id = 1;
    tick();
    halt_id = 0;
    tick();
    checks++; if (state !== 3'd4) begin failures++; $display("FAIL drain2_state actual=%0d expected=4", state); end
    rst_n = 0;
    tick();
    checks++; if (state !== 3'd0 || ctl !== 5'b00000) begin failures++; $display("FAIL abort_state actual=%0d/%b expected=0/00000", state, ctl); end
    checks++; if (cycle_count !== 32'd0) begin failures++; $display("FAIL abort_cycles actual=%0d expected=0", cycle_count); end
`ifdef STALL_COUNTER_EN
    checks++; if (stall_count !== 32'd0) begin failures++; $display("FAIL abort_stall_count actual=%0d expected=0", stall_count); end
`endif
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    test_reset();
    test_load_use();
    test_flush_priority();
    test_halt_drain();
    test_step_mode();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
